// File: rtl/ga_fitness_scheduler_pkg.sv
// Shared definitions for the GA fitness scheduler: FSM state encoding,
// the "no best yet" error constant and the slot-index width helper.
package ga_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        UPDATE  = 3'd3,
        GEN_END = 3'd4,
        BREED   = 3'd5,
        DONE    = 3'd6
    } state_e;

    // Sliced down to ErrorWidth by users; error widths above 32 bits are not expected.
    localparam logic [31:0] ERR_ONES = 32'hFFFF_FFFF;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ga_fitness_scheduler_if.sv
// Signal bundle between the fitness scheduler, the population/breeder side
// and the shared evaluator. The scheduler uses the master modport.
interface ga_fitness_scheduler_if #(
    parameter int PopulationSize  = 8,
    parameter int IndividualWidth = 64,
    parameter int ErrorWidth      = 9,
    parameter int GenerationWidth = 16
);
    localparam int IndexWidth = ga_pkg::idx_width(PopulationSize);

    logic                                  start;
    logic [PopulationSize*IndividualWidth-1:0] population;
    logic                                  evalStart;
    logic [IndividualWidth-1:0]            evalIndividual;
    logic                                  evalDone;
    logic [ErrorWidth-1:0]                 evalError;
    logic                                  scoreWrite;
    logic [IndexWidth-1:0]                 scoreIndex;
    logic [ErrorWidth-1:0]                 scoreError;
    logic                                  generationDone;
    logic                                  breedDone;
    logic [IndividualWidth-1:0]            bestIndividual;
    logic [ErrorWidth-1:0]                 bestError;
    logic [GenerationWidth-1:0]            generation;
    logic                                  busy;
    logic                                  finished;

    modport master (
        input  start, population, evalDone, evalError, breedDone,
        output evalStart, evalIndividual, scoreWrite, scoreIndex, scoreError,
               generationDone, bestIndividual, bestError, generation, busy, finished
    );

    modport slave (
        output start, population, evalDone, evalError, breedDone,
        input  evalStart, evalIndividual, scoreWrite, scoreIndex, scoreError,
               generationDone, bestIndividual, bestError, generation, busy, finished
    );

endinterface

// File: rtl/ga_fitness_scheduler_best_tracker.sv
// Best-so-far register pair: a strictly smaller error replaces the holder,
// so ties keep the individual that reached that error first.
module ga_best_tracker
    import ga_pkg::*;
#(
    parameter int IndividualWidth = 64,
    parameter int ErrorWidth      = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       update_i,
    input  logic [ErrorWidth-1:0]      error_i,
    input  logic [IndividualWidth-1:0] individual_i,
    output logic [ErrorWidth-1:0]      best_error_o,
    output logic [IndividualWidth-1:0] best_individual_o
);

    logic [ErrorWidth-1:0]      best_error_q;
    logic [IndividualWidth-1:0] best_individual_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_error_q      <= ERR_ONES[ErrorWidth-1:0];
            best_individual_q <= '0;
        end else if (clear_i) begin
            best_error_q      <= ERR_ONES[ErrorWidth-1:0];
            best_individual_q <= '0;
        end else if (update_i && (error_i < best_error_q)) begin
            best_error_q      <= error_i;
            best_individual_q <= individual_i;
        end
    end

    assign best_error_o      = best_error_q;
    assign best_individual_o = best_individual_q;

endmodule

// File: rtl/ga_fitness_scheduler.sv
// Walks the single shared evaluator over every population slot, scores each
// individual, tracks the best one and alternates with the breeder per generation.
module ga_fitness_scheduler
    import ga_pkg::*;
#(
    parameter int PopulationSize  = 8,
    parameter int IndividualWidth = 64,
    parameter int ErrorWidth      = 9,
    parameter int GenerationWidth = 16,
    parameter int MaxGenerations  = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    ga_fitness_scheduler_if.master bus
);

    localparam int                          IndexWidth = idx_width(PopulationSize);
    localparam logic [IndexWidth-1:0]       LastIndex  = IndexWidth'(PopulationSize - 1);
    localparam logic [GenerationWidth-1:0]  LastGen    = GenerationWidth'(MaxGenerations - 1);

    state_e                     state_q, state_d;
    logic [IndexWidth-1:0]      index_q, index_d;
    logic [GenerationWidth-1:0] gen_q, gen_d;
    logic [ErrorWidth-1:0]      err_q, err_d;
    logic [IndividualWidth-1:0] ind_q, ind_d;
    logic                       run_start;
    logic [ErrorWidth-1:0]      best_error;
    logic [IndividualWidth-1:0] best_individual;

    logic [IndividualWidth-1:0] slots [PopulationSize];

    for (genvar k = 0; k < PopulationSize; k++) begin : g_slot
        assign slots[k] = bus.population[k*IndividualWidth +: IndividualWidth];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            index_q <= '0;
            gen_q   <= '0;
            err_q   <= '0;
            ind_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            gen_q   <= gen_d;
            err_q   <= err_d;
            ind_q   <= ind_d;
        end
    end

    // The individual is captured on every transition into ISSUE, so the
    // population bus is ignored for the whole ISSUE/WAIT/UPDATE window.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        gen_d     = gen_q;
        err_d     = err_q;
        ind_d     = ind_q;
        run_start = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = ISSUE;
                    index_d   = '0;
                    gen_d     = '0;
                    ind_d     = slots[0];
                    run_start = 1'b1;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.evalDone) begin
                    err_d   = bus.evalError;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                if (index_q != LastIndex) begin
                    index_d = index_q + 1'b1;
                    ind_d   = slots[index_d];
                    state_d = ISSUE;
                end else begin
                    state_d = GEN_END;
                end
            end
            GEN_END: begin
                gen_d = gen_q + 1'b1;
                // best_error already reflects the last slot's score here.
                if ((best_error == '0) || (gen_q == LastGen)) state_d = DONE;
                else                                           state_d = BREED;
            end
            BREED: begin
                if (bus.breedDone) begin
                    index_d = '0;
                    ind_d   = slots[0];
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    ga_best_tracker #(
        .IndividualWidth(IndividualWidth),
        .ErrorWidth     (ErrorWidth)
    ) u_best (
        .clk              (clk),
        .rst              (rst),
        .clear_i          (run_start),
        .update_i         (state_q == UPDATE),
        .error_i          (err_q),
        .individual_i     (ind_q),
        .best_error_o     (best_error),
        .best_individual_o(best_individual)
    );

    assign bus.evalStart      = (state_q == ISSUE);
    assign bus.evalIndividual = ind_q;
    assign bus.scoreWrite     = (state_q == UPDATE);
    assign bus.scoreIndex     = index_q;
    assign bus.scoreError     = err_q;
    assign bus.generationDone = (state_q == GEN_END);
    assign bus.bestIndividual = best_individual;
    assign bus.bestError      = best_error;
    assign bus.generation     = gen_q;
    assign bus.busy           = (state_q != IDLE) && (state_q != DONE);
    assign bus.finished       = (state_q == DONE);

endmodule

// File: tb/tb_ga_fitness_scheduler.sv
// Directed bench for ga_fitness_scheduler: two instances (generation limit 1 and 3)
// share stimulus; a mux selects which one is observed and scored against a queue.
module tb_ga_fitness_scheduler;

    localparam int PS = 8;
    localparam int IW = 64;
    localparam int EW = 9;
    localparam int GW = 16;

    typedef struct packed {
        logic [2:0]    idx;
        logic [EW-1:0] err;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start;
    logic              evalDone;
    logic [EW-1:0]     evalError;
    logic              breedDone;
    logic [PS*IW-1:0]  population;
    logic              sel3;
    logic              in_breed;

    int errors = 0;
    int checks = 0;
    int n_start = 0, n_gen = 0, n_score = 0, n_breed_start = 0;

    sb_t           sb [$];
    logic [IW-1:0] slot_v [PS];
    logic [EW-1:0] mbest;
    logic [IW-1:0] mind;
    logic [EW-1:0] errs_a [PS] = '{9'd5, 9'd3, 9'd3, 9'd7, 9'd9, 9'd4, 9'd8, 9'd6};
    logic [EW-1:0] errs_b [PS] = '{9'd6, 9'd5, 9'd0, 9'd4, 9'd7, 9'd2, 9'd1, 9'd3};

    ga_fitness_scheduler_if #(.PopulationSize(PS), .IndividualWidth(IW),
                              .ErrorWidth(EW), .GenerationWidth(GW)) if1 ();
    ga_fitness_scheduler_if #(.PopulationSize(PS), .IndividualWidth(IW),
                              .ErrorWidth(EW), .GenerationWidth(GW)) if3 ();

    assign if1.start = start;          assign if3.start = start;
    assign if1.population = population; assign if3.population = population;
    assign if1.evalDone = evalDone;    assign if3.evalDone = evalDone;
    assign if1.evalError = evalError;  assign if3.evalError = evalError;
    assign if1.breedDone = breedDone;  assign if3.breedDone = breedDone;

    ga_fitness_scheduler #(.PopulationSize(PS), .IndividualWidth(IW), .ErrorWidth(EW),
                           .GenerationWidth(GW), .MaxGenerations(1))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    ga_fitness_scheduler #(.PopulationSize(PS), .IndividualWidth(IW), .ErrorWidth(EW),
                           .GenerationWidth(GW), .MaxGenerations(3))
        dut3 (.clk(clk), .rst(rst), .bus(if3));

    logic          o_evalStart, o_scoreWrite, o_genDone, o_busy, o_finished;
    logic [IW-1:0] o_evalInd, o_bestInd;
    logic [EW-1:0] o_scoreErr, o_bestErr;
    logic [2:0]    o_scoreIdx;
    logic [GW-1:0] o_gen;

    always_comb begin
        if (sel3) begin
            o_evalStart = if3.evalStart;  o_scoreWrite = if3.scoreWrite;
            o_genDone   = if3.generationDone; o_busy = if3.busy; o_finished = if3.finished;
            o_evalInd   = if3.evalIndividual; o_bestInd = if3.bestIndividual;
            o_scoreErr  = if3.scoreError; o_bestErr = if3.bestError;
            o_scoreIdx  = if3.scoreIndex; o_gen = if3.generation;
        end else begin
            o_evalStart = if1.evalStart;  o_scoreWrite = if1.scoreWrite;
            o_genDone   = if1.generationDone; o_busy = if1.busy; o_finished = if1.finished;
            o_evalInd   = if1.evalIndividual; o_bestInd = if1.bestIndividual;
            o_scoreErr  = if1.scoreError; o_bestErr = if1.bestError;
            o_scoreIdx  = if1.scoreIndex; o_gen = if1.generation;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (o_evalStart) n_start++;
            if (o_evalStart && in_breed) n_breed_start++;
            if (o_genDone) n_gen++;
            if (o_scoreWrite) n_score++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int k, input logic [IW-1:0] v);
        slot_v[k] = v;
        population[k*IW +: IW] = v;
    endtask

    task automatic fill_population();
        for (int k = 0; k < PS; k++) set_slot(k, {$urandom, $urandom});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    // opts: bit0 evalDone during ISSUE, bit1 start during WAIT, bit2 rewrite slot during WAIT
    task automatic eval_one(input int k, input logic [EW-1:0] e, input int dly, input int opts);
        int            n;
        logic [IW-1:0] cap;
        sb_t           t;
        sb_t           ex;
        n = 0;
        while (!o_evalStart && n < 40) begin
            tick();
            n++;
        end
        if (!o_evalStart) begin
            check("issue_timeout", 64'd0, 64'd1);
            return;
        end
        cap = slot_v[k];
        check("evalIndividual", o_evalInd, cap);
        if (opts[0]) begin
            evalDone  = 1'b1;
            evalError = '0;
        end
        tick();
        evalDone = 1'b0;
        if (opts[1]) pulse_start();
        if (opts[2]) set_slot(k, ~cap);
        repeat (dly) tick();
        evalDone  = 1'b1;
        evalError = e;
        t.idx = 3'(k);
        t.err = e;
        sb.push_back(t);
        tick();
        evalDone  = 1'b0;
        evalError = '0;
        check("scoreWrite", o_scoreWrite, 1);
        check("heldIndividual", o_evalInd, cap);
        if (sb.size() > 0) begin
            ex = sb.pop_front();
            check("scoreIndex", o_scoreIdx, ex.idx);
            check("scoreError", o_scoreErr, ex.err);
        end
        if (e < mbest) begin
            mbest = e;
            mind  = cap;
        end
        tick();
    endtask

    task automatic breed_phase();
        in_breed = 1'b1;
        tick();
        check("breed_busy", o_busy, 1);
        check("breed_not_finished", o_finished, 0);
        evalDone = 1'b1;
        tick();
        evalDone = 1'b0;
        tick();
        fill_population();
        tick();
        breedDone = 1'b1;
        tick();
        breedDone = 1'b0;
        in_breed  = 1'b0;
    endtask

    int b_start, b_gen, b_score;

    initial begin
        rst = 1'b1; start = 1'b0; evalDone = 1'b0; evalError = '0; breedDone = 1'b0;
        sel3 = 1'b0; in_breed = 1'b0; population = '0;
        mbest = '1; mind = '0;
        fill_population();
        #2 rst = 1'b0;
        tick(); tick();

        // Reset values
        check("rst_evalStart", o_evalStart, 0);
        check("rst_scoreWrite", o_scoreWrite, 0);
        check("rst_genDone", o_genDone, 0);
        check("rst_bestError", o_bestErr, 9'h1FF);
        check("rst_bestInd", o_bestInd, 0);
        check("rst_evalInd", o_evalInd, 0);
        check("rst_scoreIdx", o_scoreIdx, 0);
        check("rst_scoreErr", o_scoreErr, 0);
        check("rst_generation", o_gen, 0);
        check("rst_busy", o_busy, 0);
        check("rst_finished", o_finished, 0);
        rst = 1'b1;
        tick();

        // Single generation with limit 1, including spurious inputs and bus changes
        b_start = n_start; b_gen = n_gen; b_score = n_score;
        mbest = '1; mind = '0;
        pulse_start();
        check("a_busy", o_busy, 1);
        for (int k = 0; k < PS; k++)
            eval_one(k, errs_a[k], k % 3, (k == 1) ? 1 : (k == 3) ? 2 : (k == 4) ? 4 : 0);
        check("a_genDone", o_genDone, 1);
        tick();
        check("a_finished", o_finished, 1);
        check("a_busy_done", o_busy, 0);
        check("a_generation", o_gen, 1);
        check("a_bestError", o_bestErr, 3);
        check("a_bestError_model", o_bestErr, mbest);
        check("a_bestInd", o_bestInd, mind);
        tick(); tick();
        check("a_evalStarts", n_start - b_start, 8);
        check("a_genDones", n_gen - b_gen, 1);
        check("a_scoreWrites", n_score - b_score, 8);

        // Early stop on zero error, limit 3 instance
        sel3 = 1'b1;
        apply_reset();
        fill_population();
        b_start = n_start; b_gen = n_gen;
        mbest = '1; mind = '0;
        pulse_start();
        for (int k = 0; k < PS; k++) eval_one(k, errs_b[k], 1, 0);
        check("b_genDone", o_genDone, 1);
        tick();
        check("b_finished", o_finished, 1);
        check("b_generation", o_gen, 1);
        check("b_bestError", o_bestErr, 0);
        check("b_bestInd", o_bestInd, slot_v[2]);
        repeat (4) tick();
        check("b_still_done", o_finished, 1);
        check("b_evalStarts", n_start - b_start, 8);
        check("b_genDones", n_gen - b_gen, 1);

        // Restart from DONE, then three generations with breeding in between
        pulse_start();
        check("c_bestError_cleared", o_bestErr, 9'h1FF);
        check("c_generation_cleared", o_gen, 0);
        check("c_busy", o_busy, 1);
        b_start = n_start; b_gen = n_gen; b_score = n_score; n_breed_start = 0;
        mbest = '1; mind = '0;
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < PS; k++)
                eval_one(k, 9'(4 + ((k * 5 + g * 3) % 7) + (2 - g) * 2), 1, (g == 1 && k == 0) ? 1 : 0);
            check("c_genDone", o_genDone, 1);
            if (g < 2) breed_phase();
        end
        tick();
        check("c_finished", o_finished, 1);
        check("c_generation", o_gen, 3);
        check("c_bestError", o_bestErr, mbest);
        check("c_bestInd", o_bestInd, mind);
        tick(); tick();
        check("c_genDones", n_gen - b_gen, 3);
        check("c_evalStarts", n_start - b_start, 24);
        check("c_scoreWrites", n_score - b_score, 24);
        check("c_breedStarts", n_breed_start, 0);

        // Asynchronous reset while waiting on the evaluator in generation 1
        pulse_start();
        for (int k = 0; k < PS; k++) eval_one(k, 9'(10 + k), 0, 0);
        breed_phase();
        check("d_pre_generation", o_gen, 1);
        check("d_pre_issue", o_evalStart, 1);
        tick();
        b_score = n_score;
        #2 rst = 1'b0;
        #1;
        check("d_busy", o_busy, 0);
        check("d_finished", o_finished, 0);
        check("d_bestError", o_bestErr, 9'h1FF);
        check("d_bestInd", o_bestInd, 0);
        check("d_generation", o_gen, 0);
        check("d_evalStart", o_evalStart, 0);
        check("d_evalInd", o_evalInd, 0);
        tick();
        evalDone  = 1'b1;
        evalError = 9'd1;
        rst = 1'b1;
        tick();
        evalDone = 1'b0;
        repeat (3) tick();
        check("d_no_score", n_score - b_score, 0);
        check("d_idle", o_busy, 0);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ga_fitness_scheduler.md
Name: ga_fitness_scheduler

Overview:
- Sequences one shared morphologic fitness evaluator (interpreter plus error counter) across every individual of the GA population, one individual at a time.
- Records each individual's error, tracks the best individual/error over the run, counts generations, hands control to the breeding stage between generations.
- Stops on zero error or on the generation limit.
- Sits between the population register file/breeder and the single evaluator instance inside the morphologic GA top.

Parameters:
PopulationSize, 8, individuals per generation (power of two, >=2)
IndividualWidth, 64, bits per individual (instruction word)
ErrorWidth, 9, width of evaluator error result
GenerationWidth, 16, generation counter width
MaxGenerations, 1000, generation limit; must be >=1 and < 2**GenerationWidth

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  pulse; begins a run (accepted in IDLE or DONE only)
population  in  PopulationSize*IndividualWidth  flat population; slot k = bits [k*IndividualWidth +: IndividualWidth]
evalStart  out  1  one-cycle pulse launching the evaluator
evalIndividual  out  IndividualWidth  individual under evaluation; held stable from ISSUE through WAIT
evalDone  in  1  evaluator result valid (one-cycle pulse)
evalError  in  ErrorWidth  evaluator error, sampled when evalDone=1
scoreWrite  out  1  one-cycle score write strobe
scoreIndex  out  $clog2(PopulationSize)  slot being scored
scoreError  out  ErrorWidth  error being written
generationDone  out  1  one-cycle pulse: all slots scored, breeder may run
breedDone  in  1  breeder finished rewriting population
bestIndividual  out  IndividualWidth  best individual so far
bestError  out  ErrorWidth  best error so far
generation  out  GenerationWidth  completed generations
busy  out  1  high in every state except IDLE and DONE
finished  out  1  high in DONE

Behaviour:
- Reset (rst=0, async): state IDLE; every strobe 0; index 0; generation 0; bestError all-ones; bestIndividual 0; evalIndividual 0; scoreIndex/scoreError 0; busy=0, finished=0.
- IDLE: on start -> ISSUE; index=0, generation=0, bestError=all-ones, bestIndividual=0.
- ISSUE (1 cycle): evalStart=1; evalIndividual latched from slot[index] at entry; -> WAIT.
- WAIT: hold until evalDone=1; latch evalError; -> UPDATE. No timeout; waits indefinitely.
- UPDATE (1 cycle): scoreWrite=1, scoreIndex=index, scoreError=latched error. If error < bestError (strict): registered bestError/bestIndividual update, visible next cycle. Ties keep the earlier holder. If index != PopulationSize-1: index++, -> ISSUE; else -> GEN_END.
- GEN_END (1 cycle): generationDone=1; generation++. If updated bestError==0 or generation+1==MaxGenerations: -> DONE; else -> BREED.
- BREED: wait for breedDone=1; then index=0, -> ISSUE. breedDone may arrive in the first BREED cycle.
- DONE: finished=1; outputs hold; start -> same initialisation as IDLE.
- Latency: 3 cycles overhead per individual (ISSUE, WAIT entry, UPDATE) plus evaluator time.
- evalDone outside WAIT: ignored. breedDone outside BREED: ignored. start while busy: ignored.
- Population bus sampled only at ISSUE entry; changes during WAIT have no effect.
- index wraps only via the BREED->ISSUE reset to 0, never by overflow.
- rst asserted mid-run: immediate return to reset values; no pending strobe survives.

Decomposition:
- Shared package ga_pkg: state encoding constants (IDLE, ISSUE, WAIT, UPDATE, GEN_END, BREED, DONE); error all-ones constant; index width function.
- One natural sub-module: ga_best_tracker (strict-less compare plus registered bestError/bestIndividual, cleared on run start). FSM and counters stay in the top.

Test Plan:
- Reset: drive rst=0 mid-WAIT -> state IDLE, bestError=9'h1FF, generation=0, busy=0 immediately (asynchronous).
- Single generation, MaxGenerations=1, errors 5,3,3,7,9,4,8,6 -> 8 evalStart pulses, scoreIndex 0..7, bestError=3, bestIndividual=slot1 (tie keeps slot1), generationDone once, then finished=1, generation=1.
- Early stop: slot 2 error 0 in generation 0 -> slots 3..7 still evaluated; generationDone; DONE with bestError=0, generation=1; no BREED entry.
- Multi-generation: MaxGenerations=3, errors never 0, breedDone 5 cycles after each generationDone -> 3 generationDone pulses, generation=3, finished=1; zero evalStart pulses during BREED.
- Spurious inputs: evalDone pulsed during ISSUE and BREED, start pulsed in WAIT -> no scoreWrite, no state change, run unaffected.
- Stability: alter population bus during WAIT -> evalIndividual unchanged until next ISSUE; restart from DONE clears bestError to all-ones.
